// File: rtl/flash_pkg.sv
// Shared definitions for the LED-flash command controller: FSM states, key codes,
// job record layout and the flash-count clamp helper.
package flash_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    localparam logic [1:0] KEY_MODE0 = 2'd0;
    localparam logic [1:0] KEY_MODE1 = 2'd1;
    localparam logic [1:0] KEY_NEXT  = 2'd2;
    localparam logic [1:0] KEY_ABORT = 2'd3;

    localparam int              TIMES_W   = 6;
    localparam logic [TIMES_W-1:0] TIMES_MAX = 6'd31;

    typedef struct packed {
        logic               mode;
        logic [TIMES_W-1:0] times;
    } job_t;

    // The engine never completes a count of 32 or more, so presets saturate at 31.
    function automatic logic [TIMES_W-1:0] clamp_times(input logic [7:0] raw);
        if (raw > {2'b00, TIMES_MAX})
            return TIMES_MAX;
        return raw[TIMES_W-1:0];
    endfunction

endpackage

// File: rtl/flash_job_fifo.sv
// Two-entry synchronous job FIFO with flush; the head entry is visible combinationally.
module flash_job_fifo
    import flash_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  job_t       push_data_i,
    input  logic       pop_i,
    input  logic       flush_i,
    output job_t       head_o,
    output logic [1:0] count_o
);

    job_t       mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       do_push;
    logic       do_pop;

    assign do_push = push_i && (count_q != 2'd2) && !flush_i;
    assign do_pop  = pop_i && (count_q != 2'd0) && !flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push)
                wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)
                rd_ptr_q <= ~rd_ptr_q;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; occupancy is tracked solely by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (do_push)
            mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/flash_cmd_ctrl.sv
// Initiator side of the flash handshake: queues key-generated jobs, drives en/mode/times
// toward the flash engine, retires jobs on flash_done and drops stalled requests by watchdog.
module flash_cmd_ctrl
    import flash_pkg::*;
#(
    parameter logic [5:0]  TIMES_STEP  = 6'd3,
    parameter int          NUM_PRESET  = 4,
    parameter logic [31:0] TIMEOUT_CYC = 32'd2_000_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_flag,
    input  logic [1:0] key_code,
    input  logic       flash_done,
    output logic       en,
    output logic       mode,
    output logic [5:0] times,
    output logic       busy,
    output logic [1:0] pending,
    output logic       job_done,
    output logic       err
);

    localparam int             IDX_W    = (NUM_PRESET > 1) ? $clog2(NUM_PRESET) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PRESET - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        wd_q, wd_d;
    logic               mode_q, mode_d;
    logic [TIMES_W-1:0] times_q, times_d;
    logic               job_done_q, job_done_d;
    logic               err_q, err_d;

    logic               key_abort;
    logic               key_next;
    logic               key_push;
    logic               fifo_pop;
    job_t               fifo_head;
    job_t               push_job;
    logic [1:0]         fifo_cnt;
    logic [7:0]         preset_raw;

    assign key_abort = key_flag && (key_code == KEY_ABORT);
    assign key_next  = key_flag && (key_code == KEY_NEXT);
    assign key_push  = key_flag && ((key_code == KEY_MODE0) || (key_code == KEY_MODE1))
                       && (fifo_cnt != 2'd2);

    assign preset_raw = 8'(TIMES_STEP) * (8'(idx_q) + 8'd1);
    assign push_job   = '{mode: key_code[0], times: clamp_times(preset_raw)};

    flash_job_fifo u_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (key_push),
        .push_data_i (push_job),
        .pop_i       (fifo_pop),
        .flush_i     (key_abort),
        .head_o      (fifo_head),
        .count_o     (fifo_cnt)
    );

    always_comb begin
        idx_d = idx_q;
        if (key_next)
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    always_comb begin
        state_d    = state_q;
        wd_d       = wd_q;
        mode_d     = mode_q;
        times_d    = times_q;
        job_done_d = 1'b0;
        err_d      = key_abort ? 1'b0 : err_q;
        fifo_pop   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // A flush in the same cycle wins over the pop.
                if ((fifo_cnt != 2'd0) && !flash_done && !key_abort) begin
                    fifo_pop = 1'b1;
                    mode_d   = fifo_head.mode;
                    times_d  = fifo_head.times;
                    wd_d     = 32'd0;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (key_abort) begin
                    state_d = ST_RELEASE;
                end else if (flash_done) begin
                    job_done_d = 1'b1;
                    state_d    = ST_RELEASE;
                end else if (wd_q == TIMEOUT_CYC - 32'd1) begin
                    err_d   = 1'b1;
                    state_d = ST_RELEASE;
                end else begin
                    wd_d = wd_q + 32'd1;
                end
            end
            ST_RELEASE: begin
                if (!flash_done)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            wd_q       <= 32'd0;
            mode_q     <= 1'b0;
            times_q    <= '0;
            job_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wd_q       <= wd_d;
            mode_q     <= mode_d;
            times_q    <= times_d;
            job_done_q <= job_done_d;
            err_q      <= err_d;
        end
    end

    assign en       = (state_q == ST_ISSUE);
    assign busy     = (state_q != ST_IDLE);
    assign mode     = mode_q;
    assign times    = times_q;
    assign pending  = fifo_cnt;
    assign job_done = job_done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_flash_cmd_ctrl.sv
// Bench for flash_cmd_ctrl: directed vector tables, multi-cycle corner sequences and a random
// phase compared each cycle against a queue-based reference model; includes a flash engine model.
module tb_flash_cmd_ctrl;

    localparam int CNT_MAX = 4;
    localparam int TO      = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_flag = 1'b0,  key_flag2 = 1'b0;
    logic [1:0] key_code = 2'd0,  key_code2 = 2'd0;
    logic       flash_done = 1'b0, flash_done2 = 1'b0;
    logic       en, mode, busy, job_done, err;
    logic       en2, mode2, busy2, job_done2, err2;
    logic [5:0] times, times2;
    logic [1:0] pending, pending2;
    logic       hang = 1'b0;
    int         ecnt = 0, ecnt2 = 0;

    int total = 0;
    int bad   = 0;
    int nprint = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    flash_cmd_ctrl #(.TIMES_STEP(6'd3), .NUM_PRESET(4), .TIMEOUT_CYC(32'd200)) dut (
        .clk(clk), .rst(rst), .key_flag(key_flag), .key_code(key_code), .flash_done(flash_done),
        .en(en), .mode(mode), .times(times), .busy(busy), .pending(pending),
        .job_done(job_done), .err(err)
    );

    flash_cmd_ctrl #(.TIMES_STEP(6'd11), .NUM_PRESET(4), .TIMEOUT_CYC(32'd200)) dut2 (
        .clk(clk), .rst(rst), .key_flag(key_flag2), .key_code(key_code2), .flash_done(flash_done2),
        .en(en2), .mode(mode2), .times(times2), .busy(busy2), .pending(pending2),
        .job_done(job_done2), .err(err2)
    );

    // Flash engine: finishes times*CNT_MAX cycles after en, holds done while en, clears after.
    always @(posedge clk) begin
        if (!en) begin
            flash_done <= 1'b0;
            ecnt       <= 0;
        end else if (!flash_done && !hang) begin
            if (ecnt >= int'(times) * CNT_MAX) flash_done <= 1'b1;
            else ecnt <= ecnt + 1;
        end
    end

    always @(posedge clk) begin
        if (!en2) begin
            flash_done2 <= 1'b0;
            ecnt2       <= 0;
        end else if (!flash_done2) begin
            if (ecnt2 >= int'(times2) * CNT_MAX) flash_done2 <= 1'b1;
            else ecnt2 <= ecnt2 + 1;
        end
    end

    // Reference model: job queue, preset index, phase and watchdog, stepped per clock.
    typedef struct {bit m; int t;} mjob_t;
    mjob_t mq[$];
    mjob_t mj;
    int    m_phase = 0;   // 0 idle, 1 request outstanding, 2 waiting for done to drop
    int    m_idx = 0, m_wd = 0, m_times = 0;
    bit    m_mode = 0, m_jd = 0, m_err = 0;
    bit    m_abort, m_push;

    function automatic int preset(input int idx, input int step);
        int v;
        v = (step * (idx + 1)) % 256;
        return (v > 31) ? 31 : v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_phase = 0; m_idx = 0; m_wd = 0; m_times = 0;
            m_mode = 0; m_jd = 0; m_err = 0;
        end else begin
            m_abort = key_flag && (key_code == 2'd3);
            m_push  = key_flag && (key_code < 2'd2) && (mq.size() < 2);
            mj      = '{key_code[0], preset(m_idx, 3)};
            m_jd    = 0;
            if (m_phase == 0) begin
                if (mq.size() > 0 && !flash_done && !m_abort) begin
                    mjob_t j;
                    j = mq.pop_front();
                    m_mode = j.m; m_times = j.t; m_phase = 1; m_wd = 0;
                end
            end else if (m_phase == 1) begin
                if (m_abort) m_phase = 2;
                else if (flash_done) begin m_jd = 1; m_phase = 2; end
                else if (m_wd == TO - 1) begin m_err = 1; m_phase = 2; end
                else m_wd++;
            end else if (!flash_done) begin
                m_phase = 0;
            end
            if (m_push) mq.push_back(mj);
            if (m_abort) begin mq.delete(); m_err = 0; end
            if (key_flag && key_code == 2'd2) m_idx = (m_idx + 1) % 4;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [12:0] exp_v, act_v;
            exp_v = {m_phase == 1, m_mode, 6'(m_times), m_phase != 0, 2'(mq.size()), m_jd, m_err};
            act_v = {en, mode, times, busy, pending, job_done, err};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                if (nprint < 20) begin
                    nprint++;
                    $display("FAIL model t=%0t act{en,mode,times,busy,pend,jd,err}=%h required=%h",
                             $time, act_v, exp_v);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s act=%0d required=%0d", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic press(input int inst, input int c);
        if (inst == 1) begin key_flag = 1'b1; key_code = 2'(c); end
        else begin key_flag2 = 1'b1; key_code2 = 2'(c); end
        tick();
        key_flag = 1'b0; key_flag2 = 1'b0;
    endtask

    function automatic bit sig(input int w);
        case (w)
            0: return en;
            1: return job_done;
            2: return !busy;
            3: return en2;
            4: return job_done2;
            default: return !busy2;
        endcase
    endfunction

    // Returns at the negedge where the selected signal is seen; cycles=-1 on expiry.
    task automatic wait_sig(input int w, input int limit, output int cycles);
        cycles = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (sig(w)) begin cycles = i; return; end
        end
    endtask

    typedef struct {int kc; bit chk; int m; int t;} vec_t;
    vec_t tbl1[13];
    vec_t tbl2[7];

    task automatic run_vec(input int inst, input vec_t v, input string tag);
        int c, b;
        b = (inst == 1) ? 0 : 3;
        press(inst, v.kc);
        if (v.chk) begin
            wait_sig(b + 0, 10, c);
            check({tag, "_en_rise"}, c >= 0, 1);
            check({tag, "_mode"}, (inst == 1) ? int'(mode) : int'(mode2), v.m);
            check({tag, "_times"}, (inst == 1) ? int'(times) : int'(times2), v.t);
            wait_sig(b + 1, 200, c);
            check({tag, "_job_done"}, c >= 0, 1);
            wait_sig(b + 2, 10, c);
            check({tag, "_idle"}, c >= 0, 1);
        end
    endtask

    initial begin
        int c, pulses, seen_jd;
        tbl1[0]  = '{2, 0, 0, 0};  tbl1[1] = '{2, 0, 0, 0};  tbl1[2] = '{1, 1, 1, 9};
        tbl1[3]  = '{2, 0, 0, 0};  tbl1[4] = '{0, 1, 0, 12}; tbl1[5] = '{2, 0, 0, 0};
        tbl1[6]  = '{0, 1, 0, 3};
        for (int i = 7; i < 12; i++) tbl1[i] = '{2, 0, 0, 0};
        tbl1[12] = '{1, 1, 1, 6};
        tbl2[0] = '{0, 1, 0, 11}; tbl2[1] = '{2, 0, 0, 0}; tbl2[2] = '{0, 1, 0, 22};
        tbl2[3] = '{2, 0, 0, 0};  tbl2[4] = '{1, 1, 1, 31}; tbl2[5] = '{2, 0, 0, 0};
        tbl2[6] = '{0, 1, 0, 31};

        rst = 1'b1;
        tick(); chk_en = 1'b1;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_outs", {en, mode, times, busy, pending, job_done, err}, 0);
        check("rst_outs2", {en2, mode2, times2, busy2, pending2, job_done2, err2}, 0);

        // Single job: en two cycles after the key, then one job_done pulse.
        press(1, 0);
        @(negedge clk);
        check("t1_en_early", en, 0);
        check("t1_pend1", pending, 1);
        @(negedge clk);
        check("t1_en", en, 1);
        check("t1_mode", mode, 0);
        check("t1_times", times, 3);
        check("t1_pend0", pending, 0);
        wait_sig(1, 40, c);
        check("t1_jd_seen", c >= 0, 1);
        @(negedge clk);
        check("t1_jd_pulse", job_done, 0);
        check("t1_en_low", en, 0);
        wait_sig(2, 10, c);
        check("t1_idle", c >= 0, 1);
        check("t1_pend_end", pending, 0);

        for (int i = 0; i < 13; i++) run_vec(1, tbl1[i], $sformatf("tbl1_%0d", i));
        for (int i = 0; i < 7; i++) run_vec(2, tbl2[i], $sformatf("tbl2_%0d", i));

        // Three back-to-back mode0 presses while a job runs: one is dropped.
        press(1, 0);
        wait_sig(0, 10, c);
        check("t4_en", c >= 0, 1);
        tick();
        key_flag = 1'b1; key_code = 2'd0;
        tick(); tick(); tick();
        key_flag = 1'b0;
        @(negedge clk);
        check("t4_pend_peak", pending, 2);
        pulses = 0;
        c = 0;
        while (!(!busy && pending == 0) && c < 400) begin
            if (job_done) pulses++;
            c++;
            @(negedge clk);
        end
        check("t4_drained", c < 400, 1);
        check("t4_pulses", pulses, 3);

        // Engine never answers: watchdog drops en after TO cycles and sets err.
        hang = 1'b1;
        press(1, 0);
        wait_sig(0, 10, c);
        check("t5_en", c >= 0, 1);
        c = 0; seen_jd = 0;
        while (en && c < 400) begin
            if (job_done) seen_jd = 1;
            c++;
            @(negedge clk);
        end
        check("t5_en_cycles", c, TO);
        check("t5_err", err, 1);
        check("t5_no_jd", seen_jd | job_done, 0);
        hang = 1'b0;
        wait_sig(2, 10, c);
        check("t5_idle", c >= 0, 1);
        tick();
        press(1, 3);
        @(negedge clk);
        check("t5_err_clr", err, 0);

        // Abort mid-request with one job queued.
        press(1, 0);
        wait_sig(0, 10, c);
        check("t6_en", c >= 0, 1);
        tick();
        press(1, 1);
        @(negedge clk);
        check("t6_pend1", pending, 1);
        tick();
        press(1, 3);
        @(negedge clk);
        check("t6_en_drop", en, 0);
        check("t6_pend0", pending, 0);
        check("t6_no_jd", job_done, 0);
        check("t6_busy", busy, 1);
        wait_sig(2, 10, c);
        check("t6_idle", c >= 0, 1);

        // Reset in the middle of a mode1 job.
        press(1, 1);
        wait_sig(0, 10, c);
        check("t6_en2", c >= 0, 1);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_outs", {en, mode, times, busy, pending, job_done, err}, 0);

        // Random phase against the reference model.
        tick();
        for (int i = 0; i < 4000; i++) begin
            int r;
            if (i % 500 == 0) hang = ($urandom_range(0, 3) == 0);
            key_flag = ($urandom_range(0, 99) < 25);
            r = $urandom_range(0, 19);
            key_code = (r < 8) ? 2'd0 : (r < 15) ? 2'd1 : (r < 19) ? 2'd2 : 2'd3;
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        key_flag = 1'b0; rst = 1'b0; hang = 1'b0;
        for (int i = 0; i < 500; i++) tick();
        @(negedge clk);
        check("drain_idle", {busy, pending}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
